// File: rtl/sum_fifo_peak.sv
// Show-ahead FIFO that buffers strobed pair-sums for a stalling consumer.
// It also tracks the peak accepted value and a sticky overflow flag.
module sum_fifo_peak #(
  parameter int w  = 5,
  parameter int aw = 2
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          clr,
  input  logic [w-1:0]  in_data,
  input  logic          in_valid,
  output logic [w-1:0]  out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [aw:0]   count,
  output logic          full,
  output logic          empty,
  output logic          ovf,
  output logic [w-1:0]  peak
);

  localparam int depth = 1 << aw;
  localparam logic [aw:0]   cnt_full = {1'b1, {aw{1'b0}}};
  localparam logic [aw:0]   cnt_one  = 1;
  localparam logic [aw-1:0] ptr_one  = 1;

  logic [w-1:0]  mem [depth];
  logic [aw-1:0] wr_ptr;
  logic [aw-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign full      = (count == cnt_full);
  assign empty     = (count == '0);
  assign out_valid = ~empty;
  assign pop       = out_valid & out_ready;
  assign push      = in_valid & (~full | pop);

  // No bypass: a value written this edge is visible only from the next cycle.
  assign out_data  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      peak   <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      peak   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ptr_one;
      if (pop)  rd_ptr <= rd_ptr + ptr_one;
      case ({push, pop})
        2'b10:   count <= count + cnt_one;
        2'b01:   count <= count - cnt_one;
        default: count <= count;
      endcase
      // A strobe that was not accepted can only mean full without a pop.
      if (in_valid && !push) ovf <= 1'b1;
      if (push && (in_data > peak)) peak <= in_data;
    end
  end

  // Storage carries no reset; unread entries are masked by empty/count.
  always_ff @(posedge clk) begin
    if (push && !clr) mem[wr_ptr] <= in_data;
  end

endmodule

// File: doc/sum_fifo_peak.md
Name: sum_fifo_peak

Overview:
Downstream consumer of the ignore-filtered pair-sum stage. It buffers each new sum, announced by a one-cycle strobe from the producer, in a small FIFO and hands values to the next stage over a valid/ready handshake. It also tracks the peak accepted sum and flags dropped values. This decouples the free-running sum stage from a consumer that may stall.

Parameters:
w, 5, data width; matches the default sum width of the upstream stage (4-bit input + carry)
aw, 2, FIFO address bits; depth = 2**aw (default 4 entries)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_b  input  1  asynchronous, active-low reset
clr  input  1  synchronous flush: empties FIFO, clears ovf and peak
in_data  input  w  sum value from upstream stage
in_valid  input  1  one-cycle strobe: in_data is a new sum to enqueue
out_data  output  w  head-of-FIFO value (show-ahead); 0 when empty
out_valid  output  1  FIFO not empty
out_ready  input  1  consumer accepts out_data this cycle
count  output  aw+1  occupancy, 0..2**aw
full  output  1  count == 2**aw
empty  output  1  count == 0
ovf  output  1  sticky: an in_valid was dropped because FIFO full
peak  output  w  maximum in_data accepted since reset/clr

Behaviour:
- Reset (rst_b=0): takes effect immediately, no clock edge needed. Pointers, count, ovf and peak go to 0. out_data=0, out_valid=0, empty=1, full=0. Storage array is not reset.
- pop = out_valid & out_ready; push = in_valid & (~full | pop).
- Show-ahead: out_data = mem[rd_ptr] whenever out_valid=1; forced to 0 when empty.
- Push: mem[wr_ptr] <= in_data, wr_ptr++ (mod 2**aw). Written data is visible on out_data one cycle after the push edge at the earliest. No same-cycle bypass when empty.
- Pop: rd_ptr++ (mod 2**aw). Next entry is presented after the edge.
- count: +1 on push only, -1 on pop only, unchanged on both or neither. full and empty derive from count.
- Simultaneous push+pop when full: allowed. Head is consumed, new value is enqueued, count stays 2**aw, ovf is not set.
- Simultaneous push+pop when empty: impossible, since pop requires out_valid. The push proceeds and count becomes 1.
- Overflow: in_valid=1, full=1, pop=0 -> value discarded, no state change except ovf<=1. ovf holds until reset or clr.
- Peak: on push, if in_data > peak (unsigned) then peak<=in_data. Dropped values never update peak.
- clr=1 at an edge: pointers, count, ovf and peak go to 0. It overrides any push or pop in the same cycle; in_data that cycle is lost and ovf stays 0.
- out_ready while empty: ignored.
- All arithmetic is unsigned. Pointers are aw bits with natural wrap. count is aw+1 bits and never exceeds 2**aw.
- Latency: in_valid edge -> out_valid=1 after 1 cycle (empty FIFO). Throughput is 1 value/cycle in and 1 value/cycle out.

Test Plan:
- Async reset: after some pushes, drop rst_b between clock edges -> count=0, empty=1, out_valid=0, out_data=0, peak=0, ovf=0 before the next edge.
- Fill (w=5, aw=2, out_ready=0): strobe in_data 7,10,5,11 on 4 edges -> count=4, full=1, out_data=7, peak=11, ovf=0.
- Overflow: while full, in_valid with 20, out_ready=0 -> count=4, ovf=1, peak=11, out_data=7. A later drain never shows 20.
- Push+pop at full: in_valid with 30 and out_ready=1 on the same edge -> count=4, out_data=10, peak=30, ovf stays 1.
- Drain across pointer wrap: out_ready=1, in_valid=0 -> out_data sequence 10,5,11,30, then empty=1, out_valid=0, out_data=0, count=0.
- clr priority: with 2 entries held, assert clr together with in_valid with 25 and out_ready=1 -> count=0, empty=1, ovf=0, peak=0. Next push of 3 gives out_data=3 one cycle later, peak=3.
